truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequential stimulus and capture stage wrapped around the 4-input combinational function block.
- Drives the {a,b,c,d} inputs through all 16 combinations and samples the function's output f for each one.
- Assembles a 16-bit truth table and checks it against an expected mask.
- Replaces the hand-written, time-stepped stimulus with a self-checking, start/done hardware sweep usable in the testbench or as on-chip BIST.

Parameters:
- EXPECTED, 16'h87B6, expected truth table; bit i = f for {a,b,c,d}=i. Default = minterms 1,2,4,5,7,8,9,10,15.
- SETTLE, 2, extra cycles each vector is held before f is sampled. Range 0..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  begin sweep; honoured only in IDLE or DONE.
- abort  input  1  stop sweep; return to IDLE.
- f  input  1  output of the function block under test.
- a  output  1  MSB of current vector index.
- b  output  1  bit 2 of current vector index.
- c  output  1  bit 1 of current vector index.
- d  output  1  LSB of current vector index.
- busy  output  1  high while in RUN.
- done  output  1  level; high in DONE until next accepted start, abort or reset.
- tt  output  16  captured truth table.
- ones_cnt  output  5  number of 1s captured (0..16).
- mism_cnt  output  5  number of bits where captured value != EXPECTED (0..16).
- first_fail  output  4  lowest mismatching index; 0 if none.
- pass  output  1  high only in DONE with mism_cnt==0.

Behaviour:
- Reset, applied on any rising edge with rst_n=0 and in any state:
  - state=IDLE; {a,b,c,d}=0; busy=0; done=0; pass=0.
  - tt=0; ones_cnt=0; mism_cnt=0; first_fail=0.
  - Internal idx=0 and wait=0.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 and abort=0 at an edge:
  - Next state RUN; idx=0; wait=0; {a,b,c,d}=0.
  - Clear tt, ones_cnt, mism_cnt, first_fail; done=0; pass=0; busy=1.
- RUN, per edge: if wait<SETTLE, then wait++.
- RUN, sample edge (wait==SETTLE):
  - tt[idx] <= f.
  - ones_cnt += f.
  - If f != EXPECTED[idx]: mism_cnt++, and first_fail <= idx if this is the first mismatch.
  - wait <= 0.
  - If idx<15: idx++ and {a,b,c,d} <= idx+1.
  - If idx==15: state <= DONE, busy=0, done=1, pass=(final mism_cnt==0); {a,b,c,d} holds 4'hF.
- Each vector is driven for exactly SETTLE+1 cycles; f is sampled on the last edge of that window.
- Sweep latency: the DONE values are visible exactly 16*(SETTLE+1) edges after the start-accept edge (48 for SETTLE=2, 16 for SETTLE=0).
- {a,b,c,d} always equals idx; there are no glitch states between vectors.
- start while in RUN is ignored; counters are not disturbed.
- abort in RUN:
  - Next state IDLE; busy=0; done=0; pass=0.
  - tt and counters hold their partial values; {a,b,c,d} <= 0.
  - abort has priority over a coincident sample edge; that sample is discarded.
- abort in IDLE or DONE: go to IDLE; done=0; pass=0; tt and counters hold.
- start and abort together: abort wins and start is dropped.
- Counters are 5-bit; the maximum reachable value is 16, so no wrap.
- f is treated as synchronous to clk and is not resynchronised.

Test Plan:
- Correct function block, SETTLE=2, start pulse:
  - busy=1 for 48 cycles, then done=1.
  - tt=16'h87B6, ones_cnt=9, mism_cnt=0, pass=1.
  - a..d step 0..15, each held 3 cycles.
- f tied to 0:
  - tt=16'h0000, ones_cnt=0, mism_cnt=9, first_fail=1, pass=0.
- f = inverted function:
  - tt=16'h7849, mism_cnt=16, first_fail=0, pass=0.
- SETTLE=0, correct block:
  - done after 16 edges; each vector held 1 cycle; tt=16'h87B6, pass=1.
- Start repulsed mid-sweep at idx=5, with no effect:
  - Final result is identical to the first scenario.
  - Then start again from DONE: done drops, sweep restarts at idx=0, counters cleared.
- abort on the sample edge of idx=7, then separately rst_n=0 mid-sweep:
  - abort: IDLE, busy=0, tt[7] not written, {a,b,c,d}=0.
  - Reset: all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Sequential stimulus/capture wrapper around a 4-input combinational function.
// Walks {a,b,c,d} through all 16 vectors, samples f after a settle window,
// builds the truth table and scores it against an expected mask.
module truth_table_sweeper #(
    parameter logic [15:0] EXPECTED = 16'h87B6,
    parameter int unsigned SETTLE   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        f,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt,
    output logic [4:0]  ones_cnt,
    output logic [4:0]  mism_cnt,
    output logic [3:0]  first_fail,
    output logic        pass
);

    localparam logic [7:0] SETTLE_W = 8'(SETTLE);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  idx;
    logic [7:0]  wait_cnt;
    logic        is_mism;

    // The driven vector is the index register itself, so it can never glitch.
    assign {a, b, c, d} = idx;

    // Compare the live sample against the expected bit for the current vector.
    assign is_mism = (f != EXPECTED[idx]);

    // Sweep controller: start/abort handling, settle counting and capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 4'd0;
            wait_cnt   <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            tt         <= 16'd0;
            ones_cnt   <= 5'd0;
            mism_cnt   <= 5'd0;
            first_fail <= 4'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (abort) begin
                        state <= IDLE;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end else if (start) begin
                        state      <= RUN;
                        idx        <= 4'd0;
                        wait_cnt   <= 8'd0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        tt         <= 16'd0;
                        ones_cnt   <= 5'd0;
                        mism_cnt   <= 5'd0;
                        first_fail <= 4'd0;
                    end
                end

                RUN: begin
                    if (abort) begin
                        // Abort wins over a coincident sample; partial results stay visible.
                        state    <= IDLE;
                        idx      <= 4'd0;
                        wait_cnt <= 8'd0;
                        busy     <= 1'b0;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                    end else if (wait_cnt < SETTLE_W) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end else begin
                        tt[idx]  <= f;
                        ones_cnt <= ones_cnt + {4'd0, f};
                        wait_cnt <= 8'd0;
                        if (is_mism) begin
                            mism_cnt <= mism_cnt + 5'd1;
                            if (mism_cnt == 5'd0) begin
                                first_fail <= idx;
                            end
                        end
                        if (idx != 4'hF) begin
                            idx <= idx + 4'd1;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (mism_cnt == 5'd0) && !is_mism;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: two instances (SETTLE=2 and
// SETTLE=0) each driven by a behavioural function block whose personality
// (correct / stuck-at-0 / inverted) is selectable per sweep.
module tb_truth_table_sweeper;

    typedef struct packed {
        logic [15:0] tt;
        logic [4:0]  ones;
        logic [4:0]  mism;
        logic [3:0]  ff;
        logic        pass;
    } result_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start      [2];
    logic        abort      [2];
    int          fmode      [2];
    logic        f          [2];
    logic        a          [2];
    logic        b          [2];
    logic        c          [2];
    logic        d          [2];
    logic        busy       [2];
    logic        done       [2];
    logic        pass_o     [2];
    logic [15:0] tt         [2];
    logic [4:0]  ones_cnt   [2];
    logic [4:0]  mism_cnt   [2];
    logic [3:0]  first_fail [2];

    int      checks   = 0;
    int      failures = 0;
    result_t exp_q[$];

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference function: minterms 1,2,4,5,7,8,9,10,15.
    function automatic logic golden(input logic [3:0] v);
        case (v)
            4'd1, 4'd2, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10, 4'd15: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Function block personality: 0 correct, 1 stuck at 0, 2 inverted.
    function automatic logic f_model(input int mode, input logic [3:0] v);
        case (mode)
            1:       return 1'b0;
            2:       return ~golden(v);
            default: return golden(v);
        endcase
    endfunction

    assign f[0] = f_model(fmode[0], {a[0], b[0], c[0], d[0]});
    assign f[1] = f_model(fmode[1], {a[1], b[1], c[1], d[1]});

    truth_table_sweeper #(.EXPECTED(16'h87B6), .SETTLE(2)) u_dut_s2 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .f(f[0]),
        .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]), .busy(busy[0]), .done(done[0]),
        .tt(tt[0]), .ones_cnt(ones_cnt[0]), .mism_cnt(mism_cnt[0]),
        .first_fail(first_fail[0]), .pass(pass_o[0])
    );

    truth_table_sweeper #(.EXPECTED(16'h87B6), .SETTLE(0)) u_dut_s0 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .f(f[1]),
        .a(a[1]), .b(b[1]), .c(c[1]), .d(d[1]), .busy(busy[1]), .done(done[1]),
        .tt(tt[1]), .ones_cnt(ones_cnt[1]), .mism_cnt(mism_cnt[1]),
        .first_fail(first_fail[1]), .pass(pass_o[1])
    );

    function automatic logic [3:0] vec(input int sel);
        return {a[sel], b[sel], c[sel], d[sel]};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag, input int sel);
        check_output({tag, "_vec"},   32'(vec(sel)),        32'h0);
        check_output({tag, "_busy"},  32'(busy[sel]),       32'h0);
        check_output({tag, "_done"},  32'(done[sel]),       32'h0);
        check_output({tag, "_pass"},  32'(pass_o[sel]),     32'h0);
        check_output({tag, "_tt"},    32'(tt[sel]),         32'h0);
        check_output({tag, "_ones"},  32'(ones_cnt[sel]),   32'h0);
        check_output({tag, "_mism"},  32'(mism_cnt[sel]),   32'h0);
        check_output({tag, "_ff"},    32'(first_fail[sel]), 32'h0);
    endtask

    // One-cycle start pulse; returns at the falling edge after the accept edge.
    task automatic start_pulse(input int sel);
        @(negedge clk);
        start[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[sel] = 1'b0;
    endtask

    // Select the function personality, push the expected result, launch a sweep.
    task automatic apply_stimulus(input int sel, input int mode);
        result_t e;
        logic    bit_v;
        e = '0;
        for (int i = 0; i < 16; i++) begin
            bit_v   = f_model(mode, 4'(i));
            e.tt[i] = bit_v;
            e.ones  = e.ones + 5'(bit_v);
            if (bit_v != golden(4'(i))) begin
                if (e.mism == 5'd0) e.ff = 4'(i);
                e.mism = e.mism + 5'd1;
            end
        end
        e.pass = (e.mism == 5'd0);
        exp_q.push_back(e);
        fmode[sel] = mode;
        start_pulse(sel);
    endtask

    // Follow a sweep to completion, optionally poking start mid-run, then score it.
    task automatic run_to_done(input string tag, input int sel, input int settle, input int poke_edge);
        int      edges;
        int      vec_errs;
        int      busy_errs;
        int      expv;
        result_t e;
        edges     = 0;
        vec_errs  = 0;
        busy_errs = 0;
        while (done[sel] !== 1'b1 && edges < 400) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
            start[sel] = (edges == poke_edge);
            expv = edges / (settle + 1);
            if (expv > 15) expv = 15;
            if (vec(sel) !== 4'(expv)) vec_errs++;
            if (done[sel] !== 1'b1 && busy[sel] !== 1'b1) busy_errs++;
        end
        start[sel] = 1'b0;
        check_output({tag, "_edges"},     32'(edges),     32'(16 * (settle + 1)));
        check_output({tag, "_vec_seq"},   32'(vec_errs),  32'd0);
        check_output({tag, "_busy_run"},  32'(busy_errs), 32'd0);
        check_output({tag, "_busy_done"}, 32'(busy[sel]), 32'd0);
        check_output({tag, "_done"},      32'(done[sel]), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output({tag, "_tt"},   32'(tt[sel]),         32'(e.tt));
            check_output({tag, "_ones"}, 32'(ones_cnt[sel]),   32'(e.ones));
            check_output({tag, "_mism"}, 32'(mism_cnt[sel]),   32'(e.mism));
            check_output({tag, "_ff"},   32'(first_fail[sel]), 32'(e.ff));
            check_output({tag, "_pass"}, 32'(pass_o[sel]),     32'(e.pass));
        end
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence of scenarios.
    initial begin
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            start[s] = 1'b0;
            abort[s] = 1'b0;
            fmode[s] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset_s2", 0);
        check_reset("reset_s0", 1);
        rst_n = 1'b1;

        $display("[TB] correct function, SETTLE=2");
        apply_stimulus(0, 0);
        run_to_done("good_s2", 0, 2, -1);

        $display("[TB] f stuck at 0");
        apply_stimulus(0, 1);
        run_to_done("zero_s2", 0, 2, -1);

        $display("[TB] inverted function");
        apply_stimulus(0, 2);
        run_to_done("inv_s2", 0, 2, -1);

        $display("[TB] correct function, SETTLE=0");
        apply_stimulus(1, 0);
        run_to_done("good_s0", 1, 0, -1);

        $display("[TB] start repulsed mid-sweep at idx 5");
        apply_stimulus(0, 0);
        run_to_done("poke_s2", 0, 2, 16);

        $display("[TB] restart from DONE");
        apply_stimulus(0, 0);
        check_output("restart_done", 32'(done[0]),     32'd0);
        check_output("restart_busy", 32'(busy[0]),     32'd1);
        check_output("restart_vec",  32'(vec(0)),      32'd0);
        check_output("restart_tt",   32'(tt[0]),       32'd0);
        check_output("restart_ones", 32'(ones_cnt[0]), 32'd0);
        run_to_done("restart_s2", 0, 2, -1);

        $display("[TB] abort on sample edge of idx 7");
        fmode[0] = 0;
        start_pulse(0);
        repeat (23) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_output("pre_abort_vec", 32'(vec(0)), 32'd7);
        abort[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort[0] = 1'b0;
        check_output("abort_busy", 32'(busy[0]),     32'd0);
        check_output("abort_done", 32'(done[0]),     32'd0);
        check_output("abort_pass", 32'(pass_o[0]),   32'd0);
        check_output("abort_vec",  32'(vec(0)),      32'd0);
        check_output("abort_tt",   32'(tt[0]),       32'h0036);
        check_output("abort_ones", 32'(ones_cnt[0]), 32'd4);
        check_output("abort_mism", 32'(mism_cnt[0]), 32'd0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_output("abort_idle_busy", 32'(busy[0]), 32'd0);
        check_output("abort_idle_tt",   32'(tt[0]),   32'h0036);

        $display("[TB] reset mid-sweep");
        start_pulse(0);
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_output("pre_reset_busy", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset("midreset_s2", 0);
        check_reset("midreset_s0", 1);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
